// File: rtl/pipe_hazard_ctrl_if.sv
// Purpose: bundles the pipeline-side hazard inputs and the control outputs of pipe_hazard_ctrl.
// Latency: none, this is wiring only.
// Backpressure: none here; the controller's hold/bubble outputs are the pipeline's backpressure.
interface pipe_hazard_ctrl_if #(
  parameter int AW   = 3,
  parameter int NSRC = 2
);
  logic [NSRC*AW-1:0] d_src_addr;
  logic [NSRC-1:0]    d_src_used;
  logic [AW-1:0]      ex_rd;
  logic               ex_wr;
  logic               ex_ld;
  logic [AW-1:0]      mem_rd;
  logic               mem_wr;
  logic [AW-1:0]      wb_rd;
  logic               wb_wr;
  logic               redirect;
  logic               int_req;
  logic               pc_hold;
  logic               fd_hold;
  logic               de_bubble;
  logic               flush;
  logic [2*NSRC-1:0]  fwd_sel;
  logic               int_push;
  logic               int_ack;
  logic [1:0]         state;

  // Pipeline side: presents stage status, consumes control.
  modport master (
    output d_src_addr, d_src_used, ex_rd, ex_wr, ex_ld, mem_rd, mem_wr,
           wb_rd, wb_wr, redirect, int_req,
    input  pc_hold, fd_hold, de_bubble, flush, fwd_sel, int_push, int_ack, state
  );

  // Controller side.
  modport slave (
    input  d_src_addr, d_src_used, ex_rd, ex_wr, ex_ld, mem_rd, mem_wr,
           wb_rd, wb_wr, redirect, int_req,
    output pc_hold, fd_hold, de_bubble, flush, fwd_sel, int_push, int_ack, state
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Purpose: 5-stage pipeline hazard control: operand forwarding, load-use stall, redirect flush, interrupt entry.
// Latency: all controls are combinational in the detection cycle; multi-cycle sequences continue from the FSM.
// Backpressure: accepts none; pc_hold/fd_hold/de_bubble are the stall it applies to the pipeline.
module pipe_hazard_ctrl #(
  parameter int AW       = 3,
  parameter int NSRC     = 2,
  parameter int LD_STALL = 1,
  parameter int FLUSH_N  = 2,
  parameter int INT_CYC  = 2
) (
  input logic              clk,
  input logic              RESET,
  pipe_hazard_ctrl_if.slave hz
);

  // Interrupt entry: DRAIN hold cycles, then pushes, then one ack cycle at count INT_LAST.
  localparam int DRAIN    = 3;
  localparam int INT_LAST = DRAIN + INT_CYC;
  localparam int M1       = (LD_STALL > FLUSH_N) ? LD_STALL : FLUSH_N;
  localparam int CNT_MAX  = (M1 > INT_LAST + 1) ? M1 : INT_LAST + 1;
  localparam int CW       = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_LDSTALL = 2'd1,
    S_FLUSH   = 2'd2,
    S_INT     = 2'd3
  } state_t;

  state_t        cur, nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          ld_use, ld_hit;
  logic          hold, flush_c, push_c, ack_c;
  logic [2*NSRC-1:0] fwd;

  // Forwarding mux selects; the memory stage holds the younger value so it wins a double match.
  always_comb begin
    fwd = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (hz.d_src_used[i] && hz.mem_wr && (hz.mem_rd == hz.d_src_addr[i*AW +: AW]))
        fwd[2*i +: 2] = 2'b01;
      else if (hz.d_src_used[i] && hz.wb_wr && (hz.wb_rd == hz.d_src_addr[i*AW +: AW]))
        fwd[2*i +: 2] = 2'b10;
    end
  end

  // Any used decode source that the load in execute is about to write.
  always_comb begin
    ld_use = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (hz.d_src_used[i] && (hz.d_src_addr[i*AW +: AW] == hz.ex_rd))
        ld_use = 1'b1;
    end
  end

  assign ld_hit = ld_use & hz.ex_ld & hz.ex_wr;

  // State and sequence counter; reset aborts whatever sequence is in flight.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      cur <= S_RUN;
      cnt <= '0;
    end else begin
      cur <= nxt;
      cnt <= cnt_nxt;
    end
  end

  // Next state and control outputs; counter holds cycles remaining (stall/flush) or elapsed (interrupt).
  always_comb begin
    nxt     = cur;
    cnt_nxt = cnt;
    hold    = 1'b0;
    flush_c = 1'b0;
    push_c  = 1'b0;
    ack_c   = 1'b0;
    case (cur)
      S_RUN: begin
        if (hz.redirect) begin
          flush_c = 1'b1;
          if (FLUSH_N > 1) begin
            nxt     = S_FLUSH;
            cnt_nxt = CW'(FLUSH_N - 1);
          end
        end else if (ld_hit) begin
          hold = 1'b1;
          if (LD_STALL > 1) begin
            nxt     = S_LDSTALL;
            cnt_nxt = CW'(LD_STALL - 1);
          end
        end else if (hz.int_req) begin
          nxt     = S_INT;
          cnt_nxt = '0;
        end
      end
      S_LDSTALL: begin
        if (hz.redirect) begin
          // Redirect squashes the stalled instruction, so the stall is pointless.
          flush_c = 1'b1;
          if (FLUSH_N > 1) begin
            nxt     = S_FLUSH;
            cnt_nxt = CW'(FLUSH_N - 1);
          end else begin
            nxt     = S_RUN;
            cnt_nxt = '0;
          end
        end else begin
          hold = 1'b1;
          if (cnt <= CW'(1)) begin
            nxt     = S_RUN;
            cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt - CW'(1);
          end
        end
      end
      S_FLUSH: begin
        // Hazards and further redirects are wrong-path and do not extend the flush.
        flush_c = 1'b1;
        if (cnt <= CW'(1)) begin
          nxt     = S_RUN;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      S_INT: begin
        if (cnt < CW'(DRAIN)) begin
          hold    = 1'b1;
          flush_c = hz.redirect;
          cnt_nxt = cnt + CW'(1);
        end else if (cnt < CW'(INT_LAST)) begin
          hold    = 1'b1;
          push_c  = 1'b1;
          cnt_nxt = cnt + CW'(1);
        end else begin
          ack_c   = 1'b1;
          nxt     = S_RUN;
          cnt_nxt = '0;
        end
      end
      default: begin
        nxt     = S_RUN;
        cnt_nxt = '0;
      end
    endcase
  end

  // Controls are forced low while reset is held, even though RUN logic is combinational.
  assign hz.pc_hold   = RESET & hold;
  assign hz.fd_hold   = RESET & hold;
  assign hz.de_bubble = RESET & hold;
  assign hz.flush     = RESET & flush_c;
  assign hz.int_push  = RESET & push_c;
  assign hz.int_ack   = RESET & ack_c;
  assign hz.fwd_sel   = fwd;
  assign hz.state     = cur;

endmodule
